apb_controller: RTL

- APB master (initiator) side of the AHB-to-APB bridge.
- Accepts single AHB transfers decoded from the AHB slave bus and sequences them as APB SETUP/ENABLE cycles to three peripherals.
- Drives the Pselx/Penable/Pwrite/Paddr/Pwdata bundle that the APB interface block consumes, and returns Prdata to AHB as Hrdata.
- Non-pipelined: one transfer in flight; Hreadyout stalls AHB while an APB transfer is in progress.

---
 rtl/apb_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/apb_controller.sv
// APB initiator half of the AHB-to-APB bridge: accepts one decoded AHB transfer
// at a time and plays it out as an APB SETUP/ENABLE pair to one of three slots.
module apb_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic [1:0]  Htrans,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  localparam logic [31:0] WIN_SIZE = 32'd3 * SLV_SIZE;
  localparam logic [31:0] SLOT2_LO = 32'd2 * SLV_SIZE;

  // Handshake: a request is taken only on a cycle where Hreadyin, Hreadyout and
  // Htrans[1] are all high and the address hits the window; the bridge then
  // holds Hreadyout low until the APB ENABLE cycle has completed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ENABLE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr;
  logic        r_write;
  logic [2:0]  r_sel;
  logic        r_hreadyout;
  logic [2:0]  r_pselx;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [31:0] r_hrdata;

  logic [31:0] w_addr_nxt;
  logic        w_write_nxt;
  logic [2:0]  w_sel_nxt;
  logic        w_hreadyout_nxt;
  logic [2:0]  w_pselx_nxt;
  logic        w_penable_nxt;
  logic        w_pwrite_nxt;
  logic [31:0] w_paddr_nxt;
  logic [31:0] w_pwdata_nxt;
  logic [31:0] w_hrdata_nxt;

  logic [31:0] w_offset;
  logic        w_in_window;
  logic [2:0]  w_decode;
  logic        w_req_valid;

  // Offset is only meaningful when Haddr >= BASE_ADDR, which the window test guards.
  assign w_offset    = Haddr - BASE_ADDR;
  assign w_in_window = (Haddr >= BASE_ADDR) && (w_offset < WIN_SIZE);
  assign w_req_valid = Hreadyin & r_hreadyout & Htrans[1] & w_in_window;

  always_comb begin
    w_decode = 3'b000;
    if (w_offset < SLV_SIZE) begin
      w_decode = 3'b001;
    end else if (w_offset < SLOT2_LO) begin
      w_decode = 3'b010;
    end else begin
      w_decode = 3'b100;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_write_nxt     = r_write;
    w_sel_nxt       = r_sel;
    w_hreadyout_nxt = r_hreadyout;
    w_pselx_nxt     = r_pselx;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_hrdata_nxt    = r_hrdata;

    case (r_state)
      ST_IDLE: begin
        w_hreadyout_nxt = 1'b1;
        w_pselx_nxt     = 3'b000;
        w_penable_nxt   = 1'b0;
        if (w_req_valid) begin
          w_addr_nxt      = Haddr;
          w_write_nxt     = Hwrite;
          w_sel_nxt       = w_decode;
          w_hreadyout_nxt = 1'b0;
          w_state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Hwdata arrives in this data-phase cycle; taken for reads as well.
        w_hreadyout_nxt = 1'b0;
        w_pselx_nxt     = r_sel;
        w_penable_nxt   = 1'b0;
        w_paddr_nxt     = r_addr;
        w_pwrite_nxt    = r_write;
        w_pwdata_nxt    = Hwdata;
        w_state_nxt     = ST_SETUP;
      end
      ST_SETUP: begin
        w_hreadyout_nxt = 1'b0;
        w_penable_nxt   = 1'b1;
        w_state_nxt     = ST_ENABLE;
      end
      ST_ENABLE: begin
        if (!r_pwrite) begin
          w_hrdata_nxt = Prdata;
        end
        w_hreadyout_nxt = 1'b1;
        w_pselx_nxt     = 3'b000;
        w_penable_nxt   = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
      default: begin
        w_hreadyout_nxt = 1'b1;
        w_pselx_nxt     = 3'b000;
        w_penable_nxt   = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'h0;
      r_write     <= 1'b0;
      r_sel       <= 3'b000;
      r_hreadyout <= 1'b1;
      r_pselx     <= 3'b000;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 32'h0;
      r_pwdata    <= 32'h0;
      r_hrdata    <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_write     <= w_write_nxt;
      r_sel       <= w_sel_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_pselx     <= w_pselx_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_hrdata    <= w_hrdata_nxt;
    end
  end

  assign Hreadyout = r_hreadyout;
  assign Hresp     = 2'b00;
  assign Hrdata    = r_hrdata;
  assign Pselx     = r_pselx;
  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;

  // APB protocol invariants on the bundle this block drives.
  a_psel_onehot: assert property (@(posedge Hclk) disable iff (!Hresetn)
    $onehot0(Pselx));

  a_enable_follows_setup: assert property (@(posedge Hclk) disable iff (!Hresetn)
    Penable |-> ($past(Pselx) != 3'b000) && !$past(Penable) && $stable(Pselx)
                && $stable(Paddr) && $stable(Pwrite) && $stable(Pwdata));

endmodule
